cache_req_bridge: RTL and testbench



---
 rtl/cache_req_bridge.sv | 150 +++++++++++++++
 tb/tb_cache_req_bridge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_bridge.sv
// Queues tagged read/write requests and issues them one at a time to the cache IOb port.
// A read launches only when the response FIFO has a free slot, so the cache never stalls.
module cache_req_bridge #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 512,
    parameter int NBYTES      = DATA_W / 8,
    parameter int TAG_W       = 8,
    parameter int REQ_DEPTH_W = 2,
    parameter int RSP_DEPTH_W = 2
) (
    input  logic              ap_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [NBYTES-1:0] req_wstrb,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              cache_valid,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    output logic [NBYTES-1:0] cache_wstrb,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic              cache_ready,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              idle
);
    localparam int REQ_DEPTH = 2 ** REQ_DEPTH_W;
    localparam int RSP_DEPTH = 2 ** RSP_DEPTH_W;
    localparam logic [REQ_DEPTH_W:0] REQ_FULL = (REQ_DEPTH_W + 1)'(REQ_DEPTH);
    localparam logic [RSP_DEPTH_W:0] RSP_FULL = (RSP_DEPTH_W + 1)'(RSP_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [ADDR_W-1:0] req_addr_mem  [REQ_DEPTH];
    logic [DATA_W-1:0] req_wdata_mem [REQ_DEPTH];
    logic [NBYTES-1:0] req_wstrb_mem [REQ_DEPTH];
    logic [TAG_W-1:0]  req_tag_mem   [REQ_DEPTH];
    logic [REQ_DEPTH_W-1:0] req_wr_ptr, req_rd_ptr;
    logic [REQ_DEPTH_W:0]   req_cnt;

    logic [DATA_W-1:0] rsp_data_mem [RSP_DEPTH];
    logic [TAG_W-1:0]  rsp_tag_mem  [RSP_DEPTH];
    logic [RSP_DEPTH_W-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [RSP_DEPTH_W:0]   rsp_cnt;

    logic [0:0]       state;
    logic [TAG_W-1:0] issue_tag;

    logic req_push, launch, complete, rsp_push, rsp_pop, head_is_write;

    assign req_ready     = (req_cnt != REQ_FULL);
    assign rsp_valid     = (rsp_cnt != '0);
    assign idle          = (req_cnt == '0) && (rsp_cnt == '0) && (state == ST_IDLE);
    assign rsp_rdata     = rsp_data_mem[rsp_rd_ptr];
    assign rsp_tag       = rsp_tag_mem[rsp_rd_ptr];
    assign head_is_write = |req_wstrb_mem[req_rd_ptr];

    assign req_push = req_valid && req_ready;
    // With one request outstanding, a free slot now is still free when the read returns.
    assign launch   = (state == ST_IDLE) && (req_cnt != '0) &&
                      (head_is_write || (rsp_cnt != RSP_FULL));
    assign complete = (state == ST_ISSUE) && cache_ready;
    assign rsp_push = complete && (cache_wstrb == '0);
    assign rsp_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge ap_clk) begin
        if (req_push) begin
            req_addr_mem[req_wr_ptr]  <= req_addr;
            req_wdata_mem[req_wr_ptr] <= req_wdata;
            req_wstrb_mem[req_wr_ptr] <= req_wstrb;
            req_tag_mem[req_wr_ptr]   <= req_tag;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_cnt    <= '0;
        end else begin
            if (req_push) req_wr_ptr <= req_wr_ptr + REQ_DEPTH_W'(1);
            if (launch)   req_rd_ptr <= req_rd_ptr + REQ_DEPTH_W'(1);
            if (req_push && !launch)      req_cnt <= req_cnt + (REQ_DEPTH_W + 1)'(1);
            else if (!req_push && launch) req_cnt <= req_cnt - (REQ_DEPTH_W + 1)'(1);
        end
    end

    // Response storage is cleared on reset so rsp_rdata/rsp_tag read back as zero.
    always_ff @(posedge ap_clk) begin
        if (reset) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rsp_data_mem[i] <= '0;
                rsp_tag_mem[i]  <= '0;
            end
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_cnt    <= '0;
        end else begin
            if (rsp_push) begin
                rsp_data_mem[rsp_wr_ptr] <= cache_rdata;
                rsp_tag_mem[rsp_wr_ptr]  <= issue_tag;
                rsp_wr_ptr <= rsp_wr_ptr + RSP_DEPTH_W'(1);
            end
            if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + RSP_DEPTH_W'(1);
            if (rsp_push && !rsp_pop)      rsp_cnt <= rsp_cnt + (RSP_DEPTH_W + 1)'(1);
            else if (!rsp_push && rsp_pop) rsp_cnt <= rsp_cnt - (RSP_DEPTH_W + 1)'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_wstrb <= '0;
            issue_tag   <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state       <= ST_ISSUE;
                        cache_valid <= 1'b1;
                        cache_addr  <= req_addr_mem[req_rd_ptr];
                        cache_wdata <= req_wdata_mem[req_rd_ptr];
                        cache_wstrb <= req_wstrb_mem[req_rd_ptr];
                        issue_tag   <= req_tag_mem[req_rd_ptr];
                    end
                end
                default: begin
                    if (cache_ready) begin
                        state       <= ST_IDLE;
                        cache_valid <= 1'b0;
                        if (cache_wstrb == '0) rd_count <= rd_count + 32'd1;
                        else                   wr_count <= wr_count + 32'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_req_bridge.sv
// Directed bench for cache_req_bridge: latency, ordering, backpressure, full FIFO,
// reset during issue and counter wrap, with expected values computed here.
module tb_cache_req_bridge;
    logic         ap_clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [63:0]  req_addr;
    logic [511:0] req_wdata;
    logic [63:0]  req_wstrb;
    logic [7:0]   req_tag;
    logic         rsp_valid, rsp_ready;
    logic [511:0] rsp_rdata;
    logic [7:0]   rsp_tag;
    logic         cache_valid, cache_ready;
    logic [63:0]  cache_addr;
    logic [511:0] cache_wdata, cache_rdata;
    logic [63:0]  cache_wstrb;
    logic [31:0]  rd_count, wr_count;
    logic         idle;

    logic         auto_rdy, man_rdy;
    logic [511:0] man_rdata;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vrise    = 0;
    logic prev_cv = 1'b0;
    logic [63:0]  hs_addr[$];
    int           hs_cyc[$];
    logic [7:0]   rx_tag[$];
    logic [511:0] rx_data[$];

    cache_req_bridge dut (
        .ap_clk(ap_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
        .cache_valid(cache_valid), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_wstrb(cache_wstrb), .cache_rdata(cache_rdata), .cache_ready(cache_ready),
        .rd_count(rd_count), .wr_count(wr_count), .idle(idle)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [511:0] model_rdata(input logic [63:0] a);
        return {8{a ^ 64'h5A5A_0000_C3C3_0000}};
    endfunction

    // Auto mode answers in the first ISSUE cycle with address-derived data.
    assign cache_ready = auto_rdy ? cache_valid : man_rdy;
    assign cache_rdata = auto_rdy ? model_rdata(cache_addr) : man_rdata;

    always @(posedge ap_clk) begin
        if (cache_valid && cache_ready) begin
            hs_addr.push_back(cache_addr);
            hs_cyc.push_back(cyc);
        end
        if (cache_valid && !prev_cv) vrise++;
        prev_cv = cache_valid;
        if (rsp_valid && rsp_ready) begin
            rx_tag.push_back(rsp_tag);
            rx_data.push_back(rsp_rdata);
        end
        cyc++;
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        auto_rdy = 1'b0; man_rdy = 1'b0; man_rdata = '0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0; req_tag = '0;
        step();
        step();
        reset = 1'b0;
        hs_addr.delete(); hs_cyc.delete(); rx_tag.delete(); rx_data.delete();
        vrise = 0;
    endtask

    task automatic push_req(input logic [63:0] a, input logic [511:0] d,
                            input logic [63:0] s, input logic [7:0] t);
        int n = 0;
        req_addr = a; req_wdata = d; req_wstrb = s; req_tag = t; req_valid = 1'b1;
        while (!req_ready && n < 50) begin step(); n++; end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: req_ready stayed %b, required 1", req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!idle && n < 100) begin step(); n++; end
        n_checks++;
        if (!idle) begin
            n_fail++;
            $display("FAIL idle_timeout: idle=%b, required 1", idle);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cache_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cache_valid: got %b want 0", cache_valid); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", idle); end
        n_checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_fail++; $display("FAIL rst_counts: got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
        n_checks++; if (cache_addr !== '0 || cache_wdata !== '0 || cache_wstrb !== '0) begin n_fail++; $display("FAIL rst_cache_bus: got addr=%h strb=%h want 0", cache_addr, cache_wstrb); end
        n_checks++; if (rsp_rdata !== '0 || rsp_tag !== '0) begin n_fail++; $display("FAIL rst_rsp_bus: got tag=%h want 0", rsp_tag); end
        // A stray cache_ready in IDLE must not produce a response or count.
        man_rdy = 1'b1; step(); man_rdy = 1'b0; step();
        n_checks++; if (rsp_valid !== 1'b0 || rd_count !== 32'd0 || wr_count !== 32'd0) begin n_fail++; $display("FAIL idle_ready_ignored: got rsp_valid=%b rd=%0d wr=%0d want 0 0 0", rsp_valid, rd_count, wr_count); end
    endtask

    task automatic test_single_read();
        do_reset();
        push_req(64'h40, '0, '0, 8'd5);
        n_checks++; if (cache_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_t: got %b want 0", cache_valid); end
        step();
        n_checks++; if (cache_valid !== 1'b1 || cache_addr !== 64'h40 || cache_wstrb !== '0) begin n_fail++; $display("FAIL rd_issue: got v=%b addr=%h strb=%h want 1 40 0", cache_valid, cache_addr, cache_wstrb); end
        step(); step();
        n_checks++; if (cache_valid !== 1'b1 || cache_addr !== 64'h40) begin n_fail++; $display("FAIL rd_hold: got v=%b addr=%h want 1 40", cache_valid, cache_addr); end
        man_rdy = 1'b1; man_rdata = {64{8'hA5}};
        step();
        man_rdy = 1'b0; man_rdata = '0;
        n_checks++; if (rsp_valid !== 1'b1 || cache_valid !== 1'b0) begin n_fail++; $display("FAIL rd_done: got rsp_valid=%b cache_valid=%b want 1 0", rsp_valid, cache_valid); end
        n_checks++; if (rsp_tag !== 8'd5 || rsp_rdata !== {64{8'hA5}}) begin n_fail++; $display("FAIL rd_rsp: got tag=%h data=%h want 05 a5..", rsp_tag, rsp_rdata[63:0]); end
        n_checks++; if (rd_count !== 32'd1 || wr_count !== 32'd0) begin n_fail++; $display("FAIL rd_count: got rd=%0d wr=%0d want 1 0", rd_count, wr_count); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rd_drain: got rsp_valid=%b idle=%b want 0 1", rsp_valid, idle); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_addr[5];
        do_reset();
        auto_rdy = 1'b1; rsp_ready = 1'b1;
        exp_addr = '{64'h100, 64'h140, 64'h180, 64'h1C0, 64'h200};
        for (int i = 0; i < 4; i++) push_req(exp_addr[i], {16{32'hC0DE_0000 + i}}, '1, 8'(i));
        push_req(exp_addr[4], '0, '0, 8'd9);
        wait_idle();
        n_checks++; if (wr_count !== 32'd4 || rd_count !== 32'd1) begin n_fail++; $display("FAIL b2b_counts: got wr=%0d rd=%0d want 4 1", wr_count, rd_count); end
        n_checks++; if (hs_addr.size() != 5 || vrise != 5) begin n_fail++; $display("FAIL b2b_issues: got hs=%0d rises=%0d want 5 5", hs_addr.size(), vrise); end
        for (int i = 0; i < 5 && i < hs_addr.size(); i++) begin
            n_checks++; if (hs_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL b2b_order%0d: got %h want %h", i, hs_addr[i], exp_addr[i]); end
        end
        for (int i = 1; i < hs_cyc.size(); i++) begin
            n_checks++; if (hs_cyc[i] - hs_cyc[i-1] != 2) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles want 2", i, hs_cyc[i] - hs_cyc[i-1]); end
        end
        n_checks++; if (rx_tag.size() != 1 || rx_tag[0] !== 8'd9 || rx_data[0] !== model_rdata(64'h200)) begin n_fail++; $display("FAIL b2b_rsp: got %0d responses want 1 tag 09", rx_tag.size()); end
    endtask

    task automatic test_rsp_backpressure();
        do_reset();
        auto_rdy = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_req(64'h1000 + 64'(i) * 64'h40, '0, '0, 8'(i));
        repeat (5) step();
        n_checks++; if (hs_addr.size() != 4 || cache_valid !== 1'b0) begin n_fail++; $display("FAIL bp_issued: got hs=%0d cache_valid=%b want 4 0", hs_addr.size(), cache_valid); end
        n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL bp_full: got req_ready=%b rsp_valid=%b idle=%b want 0 1 0", req_ready, rsp_valid, idle); end
        n_checks++; if (rsp_tag !== 8'd0 || rsp_rdata !== model_rdata(64'h1000)) begin n_fail++; $display("FAIL bp_head: got tag=%h want 00", rsp_tag); end
        rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
        n_checks++; if (cache_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pop_cycle: got cache_valid=%b want 0", cache_valid); end
        step();
        n_checks++; if (cache_valid !== 1'b1 || cache_addr !== 64'h1100) begin n_fail++; $display("FAIL bp_fifth: got v=%b addr=%h want 1 1100", cache_valid, cache_addr); end
    endtask

    task automatic test_req_full();
        do_reset();
        for (int i = 0; i < 5; i++) push_req(64'h2000 + 64'(i) * 64'h40, {16{32'hBEEF_0000 + i}}, '1, 8'(i));
        n_checks++; if (req_ready !== 1'b0 || cache_valid !== 1'b1 || cache_addr !== 64'h2000) begin n_fail++; $display("FAIL full_state: got req_ready=%b v=%b addr=%h want 0 1 2000", req_ready, cache_valid, cache_addr); end
        req_addr = 64'h3000; req_wdata = '1; req_wstrb = '1; req_tag = 8'hFF; req_valid = 1'b1;
        man_rdy = 1'b1; step(); man_rdy = 1'b0;
        n_checks++; if (req_ready !== 1'b0 || cache_valid !== 1'b0) begin n_fail++; $display("FAIL full_complete: got req_ready=%b v=%b want 0 0", req_ready, cache_valid); end
        step();
        req_valid = 1'b0;
        n_checks++; if (cache_valid !== 1'b1 || cache_addr !== 64'h2040 || cache_wdata !== {16{32'hBEEF_0001}}) begin n_fail++; $display("FAIL full_pop: got v=%b addr=%h want 1 2040", cache_valid, cache_addr); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", req_ready); end
        auto_rdy = 1'b1;
        wait_idle();
        n_checks++; if (wr_count !== 32'd5 || hs_addr.size() != 5) begin n_fail++; $display("FAIL full_refused: got wr=%0d hs=%0d want 5 5", wr_count, hs_addr.size()); end
        n_checks++; if (hs_addr.size() == 0 || hs_addr[hs_addr.size()-1] !== 64'h2100) begin n_fail++; $display("FAIL full_last: got hs=%0d entries, last addr not 2100", hs_addr.size()); end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        push_req(64'h80, '0, '0, 8'd3);
        step();
        n_checks++; if (cache_valid !== 1'b1) begin n_fail++; $display("FAIL rii_issue: got %b want 1", cache_valid); end
        reset = 1'b1; step(); reset = 1'b0;
        man_rdy = 1'b1; man_rdata = {64{8'h3C}}; step(); man_rdy = 1'b0; step();
        n_checks++; if (rsp_valid !== 1'b0 || cache_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rii_state: got rsp_valid=%b v=%b idle=%b want 0 0 1", rsp_valid, cache_valid, idle); end
        n_checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_fail++; $display("FAIL rii_counts: got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        force dut.rd_count = 32'hFFFF_FFFF;
        #1;
        release dut.rd_count;
        n_checks++; if (rd_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", rd_count); end
        auto_rdy = 1'b1; rsp_ready = 1'b1;
        push_req(64'h4C0, '0, '0, 8'h77);
        wait_idle();
        n_checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_fail++; $display("FAIL wrap_count: got rd=%h wr=%0d want 0 0", rd_count, wr_count); end
        n_checks++; if (rx_tag.size() != 1 || rx_tag[0] !== 8'h77 || rx_data[0] !== model_rdata(64'h4C0)) begin n_fail++; $display("FAIL wrap_rsp: got %0d responses want 1 tag 77", rx_tag.size()); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_rsp_backpressure();
        test_req_full();
        test_reset_in_issue();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
